// File: rtl/rail_seq_pkg.sv
// State encodings, fault codes and a small phase helper shared by the rail sequencer.
package rail_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_UP_WAIT    = 3'd1,
    ST_UP_DELAY   = 3'd2,
    ST_ON         = 3'd3,
    ST_DOWN_WAIT  = 3'd4,
    ST_DOWN_DELAY = 3'd5,
    ST_FAULT      = 3'd6
  } seq_state_e;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_UP_WD   = 2'b01;
  localparam logic [1:0] FC_DROPOUT = 2'b10;
  localparam logic [1:0] FC_DOWN_WD = 2'b11;

  // Rails that finished their delay must stay good only while powering up or on.
  function automatic logic is_up_phase(input seq_state_e s);
    return (s == ST_UP_WAIT) || (s == ST_UP_DELAY) || (s == ST_ON);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, cleared by synchronous reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/rail_sequencer.sv
// Ordered power-up / reverse power-down of RAIL_COUNT rails with settle delay,
// PGOOD watchdog and a latched first-fault record held until clr_err.
module rail_sequencer
  import rail_seq_pkg::*;
#(
  parameter int RAIL_COUNT     = 15,
  parameter int DELAY_CYCLES   = 65536,
  parameter int TIMEOUT_CYCLES = 8388608,
  parameter int CNT_W          = 24,
  parameter int IDX_W          = $clog2(RAIL_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sysen,
  input  logic [RAIL_COUNT-1:0] pg,
  input  logic [RAIL_COUNT-1:0] rail_mask,
  input  logic [RAIL_COUNT-1:0] hold,
  input  logic                  clr_err,
  output logic [RAIL_COUNT-1:0] en,
  output logic                  sysgood,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic [IDX_W-1:0]      fault_rail,
  output logic [RAIL_COUNT-1:0] pg_snapshot,
  output logic [2:0]            state
);

  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(RAIL_COUNT - 1);

  logic                  sysen_s2;
  logic [RAIL_COUNT-1:0] pg_s2;

  sync_2ff #(.WIDTH(1)) u_sync_sysen (
    .clk (clk),
    .rst (rst),
    .d   (sysen),
    .q   (sysen_s2)
  );

  sync_2ff #(.WIDTH(RAIL_COUNT)) u_sync_pg (
    .clk (clk),
    .rst (rst),
    .d   (pg),
    .q   (pg_s2)
  );

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [RAIL_COUNT-1:0] en_q, en_d;
  logic [RAIL_COUNT-1:0] done_q, done_d;
  logic [RAIL_COUNT-1:0] snap_q, snap_d;
  logic [1:0]            code_q, code_d;
  logic [IDX_W-1:0]      frail_q, frail_d;

  logic [RAIL_COUNT-1:0] pg_up, pg_dn;
  logic                  drop_any;
  logic [IDX_W-1:0]      drop_idx;
  logic                  go_fault;
  logic [1:0]            go_code;
  logic [IDX_W-1:0]      go_rail;

  // Masked rails look good going up and already off going down.
  assign pg_up = pg_s2 | ~rail_mask;
  assign pg_dn = pg_s2 & rail_mask;

  // Descending scan so the lowest failing rail is the one reported.
  always_comb begin
    drop_any = 1'b0;
    drop_idx = '0;
    for (int i = RAIL_COUNT - 1; i >= 0; i--) begin
      if (done_q[i] && !pg_up[i] && is_up_phase(state_q)) begin
        drop_any = 1'b1;
        drop_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    en_d     = en_q;
    done_d   = done_q;
    snap_d   = snap_q;
    code_d   = code_q;
    frail_d  = frail_q;
    go_fault = 1'b0;
    go_code  = FC_NONE;
    go_rail  = idx_q;

    unique case (state_q)
      ST_OFF: begin
        en_d   = '0;
        done_d = '0;
        idx_d  = '0;
        if (sysen_s2) begin
          state_d = ST_UP_WAIT;
          en_d[0] = 1'b1;
        end
      end
      ST_UP_WAIT: begin
        if (drop_any) begin
          go_fault = 1'b1;
          go_code  = FC_DROPOUT;
          go_rail  = drop_idx;
        end else if (!sysen_s2) begin
          state_d     = ST_DOWN_WAIT;
          en_d[idx_q] = 1'b0;
        end else if (pg_up[idx_q]) begin
          state_d = ST_UP_DELAY;
        end else if (cnt_q == TIMEOUT_LAST) begin
          go_fault = 1'b1;
          go_code  = FC_UP_WD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_UP_DELAY: begin
        if (drop_any) begin
          go_fault = 1'b1;
          go_code  = FC_DROPOUT;
          go_rail  = drop_idx;
        end else if (!sysen_s2) begin
          state_d     = ST_DOWN_WAIT;
          en_d[idx_q] = 1'b0;
        end else if (cnt_q == DELAY_LAST) begin
          // A held rail parks here with the counter saturated.
          done_d[idx_q] = 1'b1;
          if (!hold[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_ON;
            end else begin
              idx_d       = idx_q + 1'b1;
              en_d[idx_d] = 1'b1;
              state_d     = ST_UP_WAIT;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ON: begin
        if (drop_any) begin
          go_fault = 1'b1;
          go_code  = FC_DROPOUT;
          go_rail  = drop_idx;
        end else if (!sysen_s2) begin
          state_d        = ST_DOWN_WAIT;
          idx_d          = LAST_IDX;
          en_d[LAST_IDX] = 1'b0;
        end
      end
      ST_DOWN_WAIT: begin
        if (!pg_dn[idx_q]) begin
          state_d = ST_DOWN_DELAY;
        end else if (cnt_q == TIMEOUT_LAST) begin
          go_fault = 1'b1;
          go_code  = FC_DOWN_WD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DOWN_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          if (idx_q == '0) begin
            state_d = ST_OFF;
          end else begin
            idx_d       = idx_q - 1'b1;
            en_d[idx_d] = 1'b0;
            state_d     = ST_DOWN_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FAULT: begin
        en_d = '0;
        if (clr_err) begin
          state_d = ST_OFF;
          code_d  = FC_NONE;
          frail_d = '0;
          snap_d  = '0;
        end
      end
      default: state_d = ST_OFF;
    endcase

    if (go_fault) begin
      state_d = ST_FAULT;
      code_d  = go_code;
      frail_d = go_rail;
      snap_d  = pg_s2;
      en_d    = '0;
    end
    if (!is_up_phase(state_d)) done_d = '0;
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      done_q  <= '0;
      snap_q  <= '0;
      code_q  <= FC_NONE;
      frail_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      done_q  <= done_d;
      snap_q  <= snap_d;
      code_q  <= code_d;
      frail_q <= frail_d;
    end
  end

  assign en          = en_q & rail_mask;
  assign sysgood     = (state_q == ST_ON);
  assign fault       = (state_q == ST_FAULT);
  assign fault_code  = code_q;
  assign fault_rail  = frail_q;
  assign pg_snapshot = snap_q;
  assign state       = state_q;

endmodule

// File: tb/tb_rail_sequencer.sv
// Scoreboard bench: stimulus queues hand-timed output events, a monitor checks each output change.
module tb_rail_sequencer;
  import rail_seq_pkg::*;

  logic       clk, rst, sysen, clr_err;
  logic [3:0] pg, rail_mask, hold, en, pg_snapshot;
  logic       sysgood, fault;
  logic [1:0] fault_code, fault_rail;
  logic [2:0] state;

  rail_sequencer #(
    .RAIL_COUNT(4), .DELAY_CYCLES(8), .TIMEOUT_CYCLES(32), .CNT_W(6)
  ) dut (
    .clk(clk), .rst(rst), .sysen(sysen), .pg(pg), .rail_mask(rail_mask),
    .hold(hold), .clr_err(clr_err), .en(en), .sysgood(sysgood), .fault(fault),
    .fault_code(fault_code), .fault_rail(fault_rail), .pg_snapshot(pg_snapshot),
    .state(state)
  );

  typedef struct {
    string      name;
    int         cyc;
    bit         poll;
    logic [2:0] st;
    logic [3:0] en;
    logic       sg;
    logic       flt;
    logic [1:0] code;
    logic [1:0] rail;
    logic [3:0] snap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, required completion", cyc);
    $fatal(1, "bench time limit reached");
  end

  // Rail model: PGOOD follows the enable through a 5-stage pipe, gated by rail health.
  logic [3:0] pipe [0:4];
  logic [3:0] alive;
  assign pg = pipe[4] & alive;

  initial begin
    for (int k = 0; k < 5; k++) pipe[k] = 4'b0;
    forever begin
      @(negedge clk);
      for (int k = 4; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = en;
    end
  end

  task automatic push_exp(input string nm, input int c, input bit poll, input logic [2:0] st,
                          input logic [3:0] e, input logic [1:0] code, input logic [1:0] rail,
                          input logic [3:0] snap);
    exp_t x;
    x.name = nm; x.cyc = c; x.poll = poll; x.st = st; x.en = e;
    x.sg = (st == ST_ON); x.flt = (st == ST_FAULT);
    x.code = code; x.rail = rail; x.snap = snap;
    exp_q.push_back(x);
  endtask

  task automatic push_st(input string nm, input int c, input logic [2:0] st, input logic [3:0] e);
    push_exp(nm, c, 1'b0, st, e, 2'b00, 2'b00, 4'b0000);
  endtask

  task automatic push_fault(input string nm, input int c, input logic [1:0] code,
                            input logic [1:0] rail, input logic [3:0] snap);
    push_exp(nm, c, 1'b0, ST_FAULT, 4'b0000, code, rail, snap);
  endtask

  task automatic check_item(input exp_t e);
    logic ok;
    checks++;
    ok = (state === e.st) && (en === e.en) && (sysgood === e.sg) && (fault === e.flt) &&
         (fault_code === e.code) && (fault_rail === e.rail) && (pg_snapshot === e.snap) &&
         (cyc == e.cyc);
    if (!ok) begin
      errors++;
      $display("FAIL %s: got cyc=%0d st=%0d en=%b sg=%b flt=%b code=%b rail=%0d snap=%b, required cyc=%0d st=%0d en=%b sg=%b flt=%b code=%b rail=%0d snap=%b",
               e.name, cyc, state, en, sysgood, fault, fault_code, fault_rail, pg_snapshot,
               e.cyc, e.st, e.en, e.sg, e.flt, e.code, e.rail, e.snap);
    end else begin
      $display("ok   %-12s cyc=%0d st=%0d en=%b sg=%b flt=%b code=%b rail=%0d snap=%b",
               e.name, cyc, state, en, sysgood, fault, fault_code, fault_rail, pg_snapshot);
    end
  endtask

  // Monitor: every change of the observable outputs consumes the next expected event.
  initial begin
    logic [16:0] obs, prev_obs;
    bit primed;
    exp_t h;
    primed = 1'b0;
    prev_obs = '0;
    forever begin
      @(negedge clk);
      obs = {state, en, sysgood, fault, fault_code, fault_rail, pg_snapshot};
      if (primed) begin
        if (exp_q.size() != 0 && exp_q[0].poll && exp_q[0].cyc <= cyc) begin
          h = exp_q.pop_front();
          check_item(h);
        end
        if (obs !== prev_obs) begin
          if (exp_q.size() == 0 || exp_q[0].poll) begin
            checks++;
            errors++;
            $display("FAIL unexpected_change: got cyc=%0d st=%0d en=%b flt=%b code=%b, required no change",
                     cyc, state, en, fault, fault_code);
          end else begin
            h = exp_q.pop_front();
            check_item(h);
          end
        end
      end
      prev_obs = obs;
      primed = 1'b1;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending events (next %s @%0d) at cyc=%0d, required 0",
               exp_q.size(), exp_q[0].name, exp_q[0].cyc, cyc);
      exp_q.delete();
    end
  endtask

  // Up sequence from en[0] at e0; stops after pushing UP_WAIT of rail 'stop'.
  task automatic exp_up(input int e0, input logic [3:0] mask, input int stop);
    int t, dly;
    logic [3:0] ev;
    bit stopped;
    t = e0; ev = 4'b0; stopped = 1'b0;
    for (int i = 0; i < 4 && !stopped; i++) begin
      ev[i] = 1'b1;
      push_st($sformatf("up_wait%0d", i), t, ST_UP_WAIT, ev & mask);
      if (i == stop) begin
        stopped = 1'b1;
      end else begin
        dly = mask[i] ? 7 : 1;
        push_st($sformatf("up_delay%0d", i), t + dly, ST_UP_DELAY, ev & mask);
        t = t + dly + 8;
      end
    end
    if (!stopped) push_st("on", t, ST_ON, ev & mask);
  endtask

  // Down sequence from rail 'top' whose enable drops at d0; pgon marks rails whose PGOOD is up.
  task automatic exp_down(input int d0, input int top, input logic [3:0] en_start,
                          input logic [3:0] mask, input logic [3:0] pgon);
    int t, dly;
    logic [3:0] ev;
    t = d0; ev = en_start;
    for (int i = top; i >= 0; i--) begin
      ev[i] = 1'b0;
      push_st($sformatf("down_wait%0d", i), t, ST_DOWN_WAIT, ev & mask);
      dly = (mask[i] && pgon[i]) ? 7 : 1;
      push_st($sformatf("down_delay%0d", i), t + dly, ST_DOWN_DELAY, ev & mask);
      t = t + dly + 8;
    end
    push_st("off", t, ST_OFF, 4'b0000);
  endtask

  task automatic clear_fault();
    sysen = 1'b0;
    wait_until(cyc + 4);
    clr_err = 1'b1;
    push_st("clear", cyc + 1, ST_OFF, 4'b0000);
    @(negedge clk);
    clr_err = 1'b0;
    wait_drain(10);
  endtask

  initial begin
    int e0, h;
    rst = 1'b1; sysen = 1'b0; clr_err = 1'b0;
    rail_mask = 4'b1111; hold = 4'b0000; alive = 4'b1111;
    push_exp("reset", 3, 1'b1, ST_OFF, 4'b0000, 2'b00, 2'b00, 4'b0000);
    wait_until(5);
    rst = 1'b0;
    wait_until(8);

    // Normal power-up, then ordered power-down from ON.
    sysen = 1'b1;
    exp_up(cyc + 3, 4'b1111, 4);
    wait_drain(200);
    sysen = 1'b0;
    exp_down(cyc + 3, 3, 4'b1111, 4'b1111, 4'b1111);
    wait_drain(200);

    // Up watchdog on rail 2.
    wait_until(cyc + 8);
    alive = 4'b1011;
    sysen = 1'b1;
    e0 = cyc + 3;
    exp_up(e0, 4'b1111, 2);
    push_fault("up_watchdog", e0 + 62, FC_UP_WD, 2'd2, 4'b0011);
    wait_drain(200);
    clear_fault();
    alive = 4'b1111;

    // Dropout of rail 1 while ON.
    wait_until(cyc + 8);
    sysen = 1'b1;
    exp_up(cyc + 3, 4'b1111, 4);
    wait_drain(200);
    alive[1] = 1'b0;
    push_fault("dropout", cyc + 3, FC_DROPOUT, 2'd1, 4'b1101);
    wait_drain(20);
    clear_fault();
    alive = 4'b1111;

    // Masked rail 2 and hold on rail 1.
    wait_until(cyc + 8);
    rail_mask = 4'b1011;
    hold = 4'b0010;
    sysen = 1'b1;
    e0 = cyc + 3;
    h = e0 + 40;
    push_st("up_wait0", e0, ST_UP_WAIT, 4'b0001);
    push_st("up_delay0", e0 + 7, ST_UP_DELAY, 4'b0001);
    push_st("up_wait1", e0 + 15, ST_UP_WAIT, 4'b0011);
    push_st("up_delay1", e0 + 22, ST_UP_DELAY, 4'b0011);
    push_exp("hold_stall", e0 + 39, 1'b1, ST_UP_DELAY, 4'b0011, 2'b00, 2'b00, 4'b0000);
    push_st("up_wait2m", h + 1, ST_UP_WAIT, 4'b0011);
    push_st("up_delay2m", h + 2, ST_UP_DELAY, 4'b0011);
    push_st("up_wait3", h + 10, ST_UP_WAIT, 4'b1011);
    push_st("up_delay3", h + 17, ST_UP_DELAY, 4'b1011);
    push_st("on_masked", h + 25, ST_ON, 4'b1011);
    wait_until(h);
    hold = 4'b0000;
    wait_drain(200);
    sysen = 1'b0;
    exp_down(cyc + 3, 3, 4'b1111, 4'b1011, 4'b1011);
    wait_drain(200);
    rail_mask = 4'b1111;

    // Early shutdown during UP_WAIT of rail 2.
    wait_until(cyc + 8);
    sysen = 1'b1;
    e0 = cyc + 3;
    exp_up(e0, 4'b1111, 2);
    wait_until(e0 + 31);
    sysen = 1'b0;
    exp_down(e0 + 34, 2, 4'b0111, 4'b1111, 4'b0011);
    wait_drain(200);

    // Reset asserted during UP_DELAY of rail 0.
    wait_until(cyc + 8);
    sysen = 1'b1;
    e0 = cyc + 3;
    push_st("up_wait0", e0, ST_UP_WAIT, 4'b0001);
    push_st("up_delay0", e0 + 7, ST_UP_DELAY, 4'b0001);
    wait_until(e0 + 9);
    rst = 1'b1;
    sysen = 1'b0;
    push_st("reset_mid", e0 + 10, ST_OFF, 4'b0000);
    wait_until(e0 + 10);
    rst = 1'b0;
    wait_drain(20);
    wait_until(cyc + 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rail_sequencer.md
# rail_sequencer

Parametrised power-rail sequencer for N rails: ordered power-up with per-step settle delay, enable-to-PGOOD watchdog, and reverse-order power-down with the same delay. It latches the first fault with its cause, rail index and a PGOOD snapshot, and holds until an explicit clear. The block sits between the synchronised system-enable and rail PGOOD pins and the rail enable pins of the system FPGA top level. Its fault/status outputs feed the I2C register file.

## Interface
- `RAIL_COUNT`, 15: number of sequenced rails; rail 0 comes up first.
- `DELAY_CYCLES`, 65536: settle time in clk cycles after a rail's PGOOD (up) or PGOOD loss (down), before the next step.
- `TIMEOUT_CYCLES`, 8388608: watchdog limit in clk cycles for PGOOD to assert (up) or deassert (down).
- `CNT_W`, 24: shared counter width; must hold max(DELAY_CYCLES, TIMEOUT_CYCLES) − 1.
- `IDX_W`, $clog2(RAIL_COUNT): rail index width.
- `clk` in 1: system clock (4.125 MHz divided clock). One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `sysen` in 1: asynchronous system enable; synchronised internally with 2 flops.
- `pg` in RAIL_COUNT: asynchronous rail PGOOD; synchronised internally with 2 flops.
- `rail_mask` in RAIL_COUNT: 1 = rail populated. A masked rail never drives `en`, counts as good when sequencing up, and counts as off when sequencing down.
- `hold` in RAIL_COUNT: 1 = do not advance past rail i once its delay has elapsed.
- `clr_err` in 1: single-cycle pulse; honoured only in FAULT.
- `en` out RAIL_COUNT: registered enable register ANDed with `rail_mask`.
- `sysgood` out 1: 1 only in ON.
- `fault` out 1: 1 in FAULT.
- `fault_code` out 2: 00 none, 01 up watchdog, 10 PGOOD dropout, 11 down watchdog.
- `fault_rail` out IDX_W: rail index of the latched fault.
- `pg_snapshot` out RAIL_COUNT: `pg_s2` captured on the cycle FAULT is entered.
- `state` out 3: current state encoding, for debug/I2C.

## Operation
- `pg_eff[i]` = `pg_s2[i]` | ~`rail_mask[i]` on power-up; `pg_s2[i]` & `rail_mask[i]` on power-down.
- `idx` is the current rail. `done[i]` is set when rail i finishes UP_DELAY and is cleared on leaving ON/UP.
- **OFF**
  - All enable and done bits are 0.
  - `sysen_s2`=1 → UP_WAIT with idx=0, en[0] set, cnt=0.
- **UP_WAIT**
  - `pg_eff[idx]` → UP_DELAY, cnt=0.
  - Otherwise cnt++. At cnt = TIMEOUT_CYCLES−1 → FAULT, code 01, rail idx.
- **UP_DELAY**
  - cnt++ until cnt = DELAY_CYCLES−1, then set done[idx].
  - If `hold[idx]`, wait with the counter saturated.
  - Else, if idx = RAIL_COUNT−1 → ON.
  - Else idx++, set en[idx], cnt=0 → UP_WAIT.
- **ON**
  - `sysen_s2`=0 → DOWN_WAIT with idx=RAIL_COUNT−1, en[idx] cleared, cnt=0.
- **Early shutdown**: `sysen_s2`=0 in UP_WAIT or UP_DELAY → DOWN_WAIT from the current idx, clearing en[idx].
- **DOWN_WAIT**
  - ~`pg_eff[idx]` → DOWN_DELAY, cnt=0.
  - Otherwise cnt++. At TIMEOUT_CYCLES−1 → FAULT, code 11.
- **DOWN_DELAY**
  - After DELAY_CYCLES: if idx=0 → OFF.
  - Else idx--, clear en[idx] → DOWN_WAIT.
  - Re-asserting `sysen` during power-down has no effect until OFF is reached. A restart then follows on the next cycle.
- **Dropout check** (UP_WAIT, UP_DELAY, ON)
  - Any i with done[i] & ~`pg_eff[i]` → FAULT, code 10, rail = lowest such i.
  - Dropout has priority over a watchdog fault in the same cycle.
- **FAULT**
  - Enable register cleared to 0 on entry; `fault_*` latched.
  - `clr_err` → OFF with fault fields cleared. If `sysen_s2` is still 1, power-up restarts from OFF on the next cycle.
- **`rst`**: state OFF; all outputs 0; counters, idx, done, fault fields and synchronisers cleared.

## Timing
- **`sysen` edge to en[0]**: 3 cycles (2 synchroniser flops plus the state register). `pg` to decision: 2 cycles plus 1.
- **UP_DELAY length**: exactly DELAY_CYCLES cycles. en[idx+1] is visible on the first cycle after UP_DELAY ends.
- **Up watchdog**: fires TIMEOUT_CYCLES cycles after UP_WAIT entry with no `pg_eff`. PGOOD arriving on the final count cycle wins over the fault.
- **Fault outputs**: `fault`, `fault_code`, `fault_rail` and `pg_snapshot` change in the same cycle the state becomes FAULT. `en` reads 0 from that cycle onwards.
- **`sysgood`**: rises the cycle ON is entered and falls the cycle ON is exited.
- **Counter**: CNT_W-bit, never wraps. It is compared for equality with the terminal value and reset on every state change.

## Structure
- **Package `rail_seq_pkg`**
  - State encodings: OFF=0, UP_WAIT=1, UP_DELAY=2, ON=3, DOWN_WAIT=4, DOWN_DELAY=5, FAULT=6.
  - Fault code constants.
- **Sub-module `sync_2ff`** (parameter WIDTH, synchronous reset to 0): used for both `sysen` and `pg`.
- **Main body**: a single FSM with one shared counter.

## Test plan
All scenarios use RAIL_COUNT=4, DELAY_CYCLES=8, TIMEOUT_CYCLES=32, all rails masked in.

1. **Normal power-up**: a model returns `pg[i]` 5 cycles after en[i] → en bits rise in order 0..3 at spaced intervals, then `sysgood`=1.
2. **Up watchdog**: rail 2 never asserts PGOOD → FAULT 32 cycles after en[2]. Expect `fault_code`=01, `fault_rail`=2, en=0000.
3. **Dropout and clear**:
   - In ON, drop `pg[1]` → code 10, rail 1, `pg_snapshot`=1101.
   - Pulse `clr_err` with `sysen`=0 → OFF, and all fault fields read 0.
4. **Masked rail and hold**:
   - rail_mask=1011 → en[2] stays 0 and sequencing passes rail 2 without waiting.
   - hold[1]=1 stalls with en=0011 until hold is released.
5. **Power-down order**: deassert `sysen` in ON → en clears 3,2,1,0, each after the previous rail's PGOOD loss plus 8 cycles, then OFF. Also deassert `sysen` during UP_WAIT of rail 2 → down-sequence starts at rail 2.
6. **Reset mid-sequence**: assert `rst` in UP_DELAY → next cycle state=OFF, en=0, `fault`=0, `sysgood`=0.
